// File: rtl/tile_sequencer.sv
// Tiled matrix-multiply command sequencer: issues fill/drain/active pulses to the
// systolic datapath and walks the input, weight and output base addresses.
module tile_sequencer #(
   parameter int unsigned WIDTH_HEIGHT = 16,
   parameter int unsigned TILE_W       = 4,
   parameter int unsigned TIMEOUT      = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [TILE_W-1:0]         num_w_tiles,
   input  logic [TILE_W-1:0]         num_in_tiles,
   input  logic [7:0]                in_base,
   input  logic [7:0]                w_base,
   input  logic [7:0]                out_base,
   input  logic                      mem_to_fifo_done,
   input  logic                      fifo_to_arr_done,
   input  logic                      output_done,
   output logic                      fill_fifo,
   output logic                      drain_fifo,
   output logic                      active,
   output logic [WIDTH_HEIGHT*8-1:0] inputMem_rd_addr_base,
   output logic [WIDTH_HEIGHT*8-1:0] weightMem_rd_addr_base,
   output logic [WIDTH_HEIGHT*8-1:0] outputMem_wr_addr_base,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [7:0]       STRIDE   = 8'(WIDTH_HEIGHT);

   typedef enum logic [3:0] {
      S_IDLE, S_FILL_ISSUE, S_FILL_WAIT, S_DRAIN_ISSUE, S_DRAIN_WAIT,
      S_MM_ISSUE, S_MM_WAIT, S_NEXT, S_FINISH, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [TILE_W-1:0] num_w_q, num_w_d, num_in_q, num_in_d;
   logic [TILE_W-1:0] wi_q, wi_d, ii_q, ii_d;
   logic [7:0]        in_base_q, in_base_d;
   logic [7:0]        in_addr_q, in_addr_d, w_addr_q, w_addr_d, out_addr_q, out_addr_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              fill_q, fill_d, drain_q, drain_d, active_q, active_d;
   logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic              more_in, more_w;

   assign more_in = ({1'b0, ii_q} + (TILE_W+1)'(1)) < {1'b0, num_in_q};
   assign more_w  = ({1'b0, wi_q} + (TILE_W+1)'(1)) < {1'b0, num_w_q};

   always_comb begin
      state_d    = state_q;
      num_w_d    = num_w_q;
      num_in_d   = num_in_q;
      in_base_d  = in_base_q;
      wi_d       = wi_q;
      ii_d       = ii_q;
      in_addr_d  = in_addr_q;
      w_addr_d   = w_addr_q;
      out_addr_d = out_addr_q;
      wait_d     = wait_q;
      error_d    = error_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               num_w_d    = num_w_tiles;
               num_in_d   = num_in_tiles;
               in_base_d  = in_base;
               wi_d       = '0;
               ii_d       = '0;
               in_addr_d  = in_base;
               w_addr_d   = w_base;
               out_addr_d = out_base;
               error_d    = 1'b0;
               state_d    = (num_w_tiles == '0 || num_in_tiles == '0) ? S_FINISH : S_FILL_ISSUE;
            end
         end
         S_FILL_ISSUE: begin
            wait_d  = '0;
            state_d = S_FILL_WAIT;
         end
         S_FILL_WAIT: begin
            if (mem_to_fifo_done) state_d = S_DRAIN_ISSUE;
            else if (wait_q == WAIT_MAX) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else wait_d = wait_q + CNT_W'(1);
         end
         S_DRAIN_ISSUE: begin
            wait_d  = '0;
            state_d = S_DRAIN_WAIT;
         end
         S_DRAIN_WAIT: begin
            if (fifo_to_arr_done) state_d = S_MM_ISSUE;
            else if (wait_q == WAIT_MAX) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else wait_d = wait_q + CNT_W'(1);
         end
         S_MM_ISSUE: begin
            wait_d  = '0;
            state_d = S_MM_WAIT;
         end
         S_MM_WAIT: begin
            if (output_done) state_d = S_NEXT;
            else if (wait_q == WAIT_MAX) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else wait_d = wait_q + CNT_W'(1);
         end
         S_NEXT: begin
            // Addresses advance by the stride alongside the counters; the output
            // tile index wi*num_in+ii grows by one on every advance, so no multiplier.
            if (more_in) begin
               ii_d       = ii_q + TILE_W'(1);
               in_addr_d  = in_addr_q + STRIDE;
               out_addr_d = out_addr_q + STRIDE;
               state_d    = S_MM_ISSUE;
            end else if (more_w) begin
               wi_d       = wi_q + TILE_W'(1);
               ii_d       = '0;
               in_addr_d  = in_base_q;
               w_addr_d   = w_addr_q + STRIDE;
               out_addr_d = out_addr_q + STRIDE;
               state_d    = S_FILL_ISSUE;
            end else state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      fill_d   = (state_d == S_FILL_ISSUE);
      drain_d  = (state_d == S_DRAIN_ISSUE);
      active_d = (state_d == S_MM_ISSUE);
      busy_d   = (state_d != S_IDLE) && (state_d != S_ERR);
      done_d   = (state_d == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         num_w_q    <= '0;
         num_in_q   <= '0;
         in_base_q  <= '0;
         wi_q       <= '0;
         ii_q       <= '0;
         in_addr_q  <= '0;
         w_addr_q   <= '0;
         out_addr_q <= '0;
         wait_q     <= '0;
         fill_q     <= 1'b0;
         drain_q    <= 1'b0;
         active_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_w_q    <= num_w_d;
         num_in_q   <= num_in_d;
         in_base_q  <= in_base_d;
         wi_q       <= wi_d;
         ii_q       <= ii_d;
         in_addr_q  <= in_addr_d;
         w_addr_q   <= w_addr_d;
         out_addr_q <= out_addr_d;
         wait_q     <= wait_d;
         fill_q     <= fill_d;
         drain_q    <= drain_d;
         active_q   <= active_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign fill_fifo              = fill_q;
   assign drain_fifo             = drain_q;
   assign active                 = active_q;
   assign busy                   = busy_q;
   assign done                   = done_q;
   assign error                  = error_q;
   assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_addr_q}};
   assign weightMem_rd_addr_base = {WIDTH_HEIGHT{w_addr_q}};
   assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_addr_q}};

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: a datapath responder answers each command pulse, and the
// recorded pulse/address trace is compared against a loop-built reference sequence.
module tb_tile_sequencer;
   localparam int WH = 16;
   localparam int TW = 4;
   localparam int TO = 1024;

   logic            clk = 1'b0;
   logic            reset, start;
   logic [TW-1:0]   num_w_tiles, num_in_tiles;
   logic [7:0]      in_base, w_base, out_base;
   logic            mem_to_fifo_done, fifo_to_arr_done, output_done;
   logic            fill_fifo, drain_fifo, active, busy, done, error;
   logic [WH*8-1:0] in_bus, w_bus, out_bus;

   tile_sequencer #(.WIDTH_HEIGHT(WH), .TILE_W(TW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .num_w_tiles(num_w_tiles), .num_in_tiles(num_in_tiles),
      .in_base(in_base), .w_base(w_base), .out_base(out_base),
      .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done),
      .output_done(output_done),
      .fill_fifo(fill_fifo), .drain_fifo(drain_fifo), .active(active),
      .inputMem_rd_addr_base(in_bus), .weightMem_rd_addr_base(w_bus),
      .outputMem_wr_addr_base(out_bus),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // responder behaviour knobs
   int resp_lat    = 3;
   bit hold_all    = 1'b0;
   bit hold_out    = 1'b0;
   bit block_drain = 1'b0;
   bit block_out   = 1'b0;

   // trace entry: {cmd(1 fill,2 drain,3 active), in addr, w addr, out addr}
   logic [25:0] evq[$];
   int done_cnt, multi_err, lane_err, busy_err;

   initial begin
      int fc, dc, mc;
      fc = 0; dc = 0; mc = 0;
      mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
      forever begin
         @(negedge clk);
         mem_to_fifo_done = hold_all;
         fifo_to_arr_done = hold_all && !block_drain;
         output_done      = hold_all || hold_out;
         if (reset) begin fc = 0; dc = 0; mc = 0; end
         if (fc > 0) begin fc--; if (fc == 0) mem_to_fifo_done = 1'b1; end
         if (dc > 0) begin dc--; if (dc == 0 && !block_drain) fifo_to_arr_done = 1'b1; end
         if (mc > 0) begin mc--; if (mc == 0 && !block_out) output_done = 1'b1; end
         if (fill_fifo)  fc = resp_lat;
         if (drain_fifo) dc = resp_lat;
         if (active)     mc = resp_lat;
      end
   end

   always @(posedge clk) begin
      #1;
      if (int'(fill_fifo) + int'(drain_fifo) + int'(active) > 1) multi_err++;
      if (in_bus !== {WH{in_bus[7:0]}} || w_bus !== {WH{w_bus[7:0]}} || out_bus !== {WH{out_bus[7:0]}})
         lane_err++;
      if ((fill_fifo || drain_fifo || active) && !busy) busy_err++;
      if (fill_fifo)  evq.push_back({2'd1, in_bus[7:0], w_bus[7:0], out_bus[7:0]});
      if (drain_fifo) evq.push_back({2'd2, in_bus[7:0], w_bus[7:0], out_bus[7:0]});
      if (active)     evq.push_back({2'd3, in_bus[7:0], w_bus[7:0], out_bus[7:0]});
      if (done) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      evq.delete();
      done_cnt = 0; multi_err = 0; lane_err = 0; busy_err = 0;
   endtask

   task automatic kick(input int nw, input int ni, input logic [7:0] ib, input logic [7:0] wb,
                       input logic [7:0] ob);
      @(negedge clk);
      num_w_tiles = 4'(nw); num_in_tiles = 4'(ni);
      in_base = ib; w_base = wb; out_base = ob;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_seq(input string name, input int nw, input int ni, input logic [7:0] ib,
                          input logic [7:0] wb, input logic [7:0] ob, input bit intrude,
                          input int exp_lat);
      logic [25:0] exq[$];
      int lat;
      for (int wi = 0; wi < nw && ni > 0; wi++) begin
         exq.push_back({2'd1, ib, 8'(wb + wi*16), 8'(ob + wi*ni*16)});
         exq.push_back({2'd2, ib, 8'(wb + wi*16), 8'(ob + wi*ni*16)});
         for (int ii = 0; ii < ni; ii++)
            exq.push_back({2'd3, 8'(ib + ii*16), 8'(wb + wi*16), 8'(ob + (wi*ni + ii)*16)});
      end
      clear_mon();
      kick(nw, ni, ib, wb, ob);
      tests++;
      if (nw == 0 || ni == 0) begin
         if ({done, busy, fill_fifo, drain_fifo, active} !== 5'b11000) begin
            fails++;
            $display("FAIL %s_first_cycle: got %b expected 11000", name,
                     {done, busy, fill_fifo, drain_fifo, active});
         end
      end else if ({fill_fifo, busy, error} !== 3'b110) begin
         fails++;
         $display("FAIL %s_first_cycle: got %b expected 110", name, {fill_fifo, busy, error});
      end
      lat = 0;
      for (int k = 1; k <= 4000; k++) begin
         if (done) begin lat = k; break; end
         start = intrude && (k == 4);
         if (intrude && k == 4) begin
            num_w_tiles = 4'($urandom); num_in_tiles = 4'($urandom);
            in_base = 8'($urandom); w_base = 8'($urandom); out_base = 8'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      tests++;
      if (lat == 0) begin
         fails++;
         $display("FAIL %s_done_seen: got no done expected done within 4000 cycles", name);
      end else if (busy !== 1'b1) begin
         fails++;
         $display("FAIL %s_busy_in_finish: got %b expected 1", name, busy);
      end
      if (exp_lat >= 0) begin
         tests++;
         if (lat != exp_lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
         end
      end
      repeat (3) @(negedge clk);
      tests++;
      if (done_cnt != 1) begin
         fails++;
         $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
      end
      tests++;
      if (evq.size() != exq.size()) begin
         fails++;
         $display("FAIL %s_pulse_count: got %0d expected %0d", name, evq.size(), exq.size());
      end
      for (int j = 0; j < exq.size() && j < evq.size(); j++) begin
         tests++;
         if (evq[j] !== exq[j]) begin
            fails++;
            $display("FAIL %s_event%0d: got cmd%0d in=%h w=%h out=%h expected cmd%0d in=%h w=%h out=%h",
                     name, j, evq[j][25:24], evq[j][23:16], evq[j][15:8], evq[j][7:0],
                     exq[j][25:24], exq[j][23:16], exq[j][15:8], exq[j][7:0]);
         end
      end
      tests++;
      if (multi_err != 0 || lane_err != 0 || busy_err != 0) begin
         fails++;
         $display("FAIL %s_invariants: got multi=%0d lane=%0d busy=%0d expected 0 0 0", name,
                  multi_err, lane_err, busy_err);
      end
      tests++;
      if ({busy, error} !== 2'b00) begin
         fails++;
         $display("FAIL %s_idle_after: got busy/error %b expected 00", name, {busy, error});
      end
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1; start = 1'b0;
      num_w_tiles = '0; num_in_tiles = '0; in_base = '0; w_base = '0; out_base = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({fill_fifo, drain_fifo, active} !== 3'b000) begin
         fails++;
         $display("FAIL reset_pulses: got %b expected 000", {fill_fifo, drain_fifo, active});
      end
      tests++;
      if ({busy, done, error} !== 3'b000) begin
         fails++;
         $display("FAIL reset_status: got %b expected 000", {busy, done, error});
      end
      tests++;
      if (in_bus !== '0 || w_bus !== '0 || out_bus !== '0) begin
         fails++;
         $display("FAIL reset_addr: got %h %h %h expected 0", in_bus[7:0], w_bus[7:0], out_bus[7:0]);
      end
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if ({fill_fifo, drain_fifo, active, busy, done, error} !== 6'b0 || out_bus !== '0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_basic();
      resp_lat = 3;
      run_seq("basic", 1, 1, 8'h10, 8'h20, 8'h30, 1'b0, -1);
   endtask

   task automatic test_wrap();
      resp_lat = 3;
      run_seq("wrap", 2, 3, 8'h05, 8'h40, 8'hF0, 1'b0, -1);
   endtask

   task automatic test_min_latency();
      hold_all = 1'b1;
      run_seq("min_latency", 1, 1, 8'h01, 8'h02, 8'h03, 1'b0, 8);
      run_seq("all_flags_held", 2, 2, 8'h80, 8'h90, 8'hA0, 1'b0, -1);
      hold_all = 1'b0;
   endtask

   task automatic test_stale_level();
      hold_out = 1'b1; resp_lat = 2;
      run_seq("output_done_held", 2, 3, 8'h11, 8'h22, 8'h33, 1'b0, -1);
      hold_out = 1'b0;
   endtask

   task automatic test_zero_count();
      run_seq("zero_in", 3, 0, 8'h10, 8'h20, 8'h30, 1'b0, 1);
      run_seq("zero_w", 0, 2, 8'h10, 8'h20, 8'h30, 1'b0, 1);
   endtask

   task automatic test_timeout();
      int kd, ke;
      block_drain = 1'b1; resp_lat = 2;
      clear_mon();
      kick(1, 1, 8'h44, 8'h55, 8'h66);
      kd = -1; ke = -1;
      for (int k = 1; k <= 3000; k++) begin
         if (drain_fifo && kd < 0) kd = k;
         if (error) begin ke = k; break; end
         @(negedge clk);
      end
      tests++;
      if (kd < 0 || ke < 0 || ke - kd != TO + 1) begin
         fails++;
         $display("FAIL timeout_length: got drain@%0d error@%0d expected gap %0d", kd, ke, TO + 1);
      end
      tests++;
      if ({busy, done, error} !== 3'b001) begin
         fails++;
         $display("FAIL timeout_status: got %b expected 001", {busy, done, error});
      end
      repeat (20) @(negedge clk);
      tests++;
      if ({busy, error} !== 2'b01) begin
         fails++;
         $display("FAIL error_sticky: got %b expected 01", {busy, error});
      end
      tests++;
      if (done_cnt != 0 || evq.size() != 2) begin
         fails++;
         $display("FAIL timeout_no_done: got done=%0d pulses=%0d expected 0 2", done_cnt, evq.size());
      end
      block_drain = 1'b0;
      run_seq("restart_after_err", 1, 2, 8'h44, 8'h55, 8'h66, 1'b0, -1);
   endtask

   task automatic test_reset_mid();
      int bad;
      block_out = 1'b1; resp_lat = 2;
      clear_mon();
      kick(2, 2, 8'h12, 8'h34, 8'h56);
      for (int k = 0; k < 200 && !active; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if ({fill_fifo, drain_fifo, active, busy, done, error} !== 6'b0 ||
          in_bus !== '0 || w_bus !== '0 || out_bus !== '0) begin
         fails++;
         $display("FAIL reset_mid: got ctl=%b out=%h expected all 0",
                  {fill_fifo, drain_fifo, active, busy, done, error}, out_bus[7:0]);
      end
      block_out = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if ({fill_fifo, drain_fifo, active, busy, done} !== 5'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_start_while_busy();
      resp_lat = 2;
      run_seq("start_ignored", 2, 2, 8'h21, 8'h43, 8'h65, 1'b1, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         resp_lat = $urandom_range(1, 4);
         run_seq($sformatf("random%0d", i), $urandom_range(1, 3), $urandom_range(1, 3),
                 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_min_latency();
      test_stale_level();
      test_zero_count();
      test_timeout();
      test_reset_mid();
      test_start_while_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
